// File: rtl/debounce_switch_bank.sv
// Multi-channel switch debouncer: 2-flop sync, per-channel stability counter, rise/fall pulses.
// Optional long-press detector compiled in with DEBOUNCE_SWITCH_BANK_LONG_EN.
module debounce_switch_bank #(
    parameter int NUM_CH         = 4,
    parameter int DEBOUNCE_LIMIT = 250000,
    parameter int CNT_W          = 18,
    parameter int LONG_TICKS     = 100,
    parameter int LONG_W         = 8
) (
    input  logic              i_Clk,
    input  logic              i_Rst,
    input  logic [NUM_CH-1:0] i_Switch,
    output logic [NUM_CH-1:0] o_Switch,
    output logic [NUM_CH-1:0] o_Rise,
    output logic [NUM_CH-1:0] o_Fall,
    output logic [NUM_CH-1:0] o_Long
);

    localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(DEBOUNCE_LIMIT - 1);
    localparam logic [CNT_W-1:0] LP_CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    if ((NUM_CH < 1) || (DEBOUNCE_LIMIT < 2) || ((2 ** CNT_W) <= DEBOUNCE_LIMIT) ||
        (LONG_TICKS < 1) || (LONG_TICKS > ((2 ** LONG_W) - 1))) begin : g_param_err
        $error("debounce_switch_bank: illegal parameter combination");
    end

    logic [NUM_CH-1:0] r_Sync1;
    logic [NUM_CH-1:0] r_Sync2;
    logic [NUM_CH-1:0] r_State;
    logic [NUM_CH-1:0] r_Rise;
    logic [NUM_CH-1:0] r_Fall;
    logic [CNT_W-1:0]  r_Cnt [NUM_CH];
    logic [NUM_CH-1:0] w_Diff;
    logic [NUM_CH-1:0] w_Accept;

    // Two-flop synchroniser for the asynchronous switch pins
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_Sync1 <= {NUM_CH{1'b0}};
            r_Sync2 <= {NUM_CH{1'b0}};
        end else begin
            r_Sync1 <= i_Switch;
            r_Sync2 <= r_Sync1;
        end
    end

    // Acceptance: synchronised level has differed for DEBOUNCE_LIMIT consecutive clocks
    always_comb begin
        w_Diff   = r_Sync2 ^ r_State;
        w_Accept = {NUM_CH{1'b0}};
        for (int i = 0; i < NUM_CH; i++) begin
            w_Accept[i] = w_Diff[i] && (r_Cnt[i] == LP_CNT_LAST);
        end
    end

    // Stability counters, debounced state and edge pulses
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_Cnt[i] <= {CNT_W{1'b0}};
            end
            r_State <= {NUM_CH{1'b0}};
            r_Rise  <= {NUM_CH{1'b0}};
            r_Fall  <= {NUM_CH{1'b0}};
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_Accept[i]) begin
                    r_Cnt[i] <= {CNT_W{1'b0}};
                end else if (w_Diff[i]) begin
                    r_Cnt[i] <= r_Cnt[i] + LP_CNT_ONE;
                end else begin
                    r_Cnt[i] <= {CNT_W{1'b0}};
                end
            end
            r_State <= r_State ^ w_Accept;
            r_Rise  <= w_Accept & r_Sync2;
            r_Fall  <= w_Accept & ~r_Sync2;
        end
    end

    assign o_Switch = r_State;
    assign o_Rise   = r_Rise;
    assign o_Fall   = r_Fall;

`ifdef DEBOUNCE_SWITCH_BANK_LONG_EN
    localparam logic [LONG_W-1:0] LP_HOLD_MAX = LONG_W'(LONG_TICKS);
    localparam logic [LONG_W-1:0] LP_HOLD_ONE = {{(LONG_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0]  r_Pre;
    logic              w_Tick;
    logic [LONG_W-1:0] r_Hold [NUM_CH];
    logic [NUM_CH-1:0] r_Fired;
    logic [NUM_CH-1:0] r_Long;

    assign w_Tick = (r_Pre == LP_CNT_LAST);

    // Shared free-running prescaler, one tick per DEBOUNCE_LIMIT clocks
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_Pre <= {CNT_W{1'b0}};
        end else if (w_Tick) begin
            r_Pre <= {CNT_W{1'b0}};
        end else begin
            r_Pre <= r_Pre + LP_CNT_ONE;
        end
    end

    // Per-channel hold counters; r_Fired blocks repeats until the channel is released
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_Hold[i] <= {LONG_W{1'b0}};
            end
            r_Fired <= {NUM_CH{1'b0}};
            r_Long  <= {NUM_CH{1'b0}};
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (!r_State[i]) begin
                    r_Hold[i] <= {LONG_W{1'b0}};
                end else if (w_Tick && (r_Hold[i] != LP_HOLD_MAX)) begin
                    r_Hold[i] <= r_Hold[i] + LP_HOLD_ONE;
                end else begin
                    r_Hold[i] <= r_Hold[i];
                end
                r_Long[i]  <= r_State[i] && (r_Hold[i] == LP_HOLD_MAX) && !r_Fired[i];
                r_Fired[i] <= r_State[i] && (r_Fired[i] || (r_Hold[i] == LP_HOLD_MAX));
            end
        end
    end

    assign o_Long = r_Long;
`else
    assign o_Long = {NUM_CH{1'b0}};
`endif

endmodule

// File: tb/tb_debounce_switch_bank.sv
// Randomised + directed bench for debounce_switch_bank against a window-based reference model.
module tb_debounce_switch_bank;

    localparam int NCH = 4;
    localparam int LIM = 8;
    localparam int CW  = 4;
    localparam int LT  = 4;
    localparam int LW  = 3;
`ifdef DEBOUNCE_SWITCH_BANK_LONG_EN
    localparam bit LONG_ON = 1'b1;
`else
    localparam bit LONG_ON = 1'b0;
`endif

    logic           i_Clk    = 1'b0;
    logic           i_Rst    = 1'b0;
    logic [NCH-1:0] i_Switch = 4'h0;
    logic [NCH-1:0] o_Switch;
    logic [NCH-1:0] o_Rise;
    logic [NCH-1:0] o_Fall;
    logic [NCH-1:0] o_Long;

    debounce_switch_bank #(
        .NUM_CH(NCH), .DEBOUNCE_LIMIT(LIM), .CNT_W(CW), .LONG_TICKS(LT), .LONG_W(LW)
    ) u_dut (
        .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Switch(i_Switch),
        .o_Switch(o_Switch), .o_Rise(o_Rise), .o_Fall(o_Fall), .o_Long(o_Long)
    );

    always #5 i_Clk = ~i_Clk;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    logic [NCH-1:0] m_state;
    logic [NCH-1:0] exp_rise, exp_fall, exp_long, m_due;
    logic [NCH-1:0] q_raw [$];
    logic [NCH-1:0] q_s2 [$];
    int             m_ticks [NCH];
    int             m_edge;

    // observation bookkeeping, edge indices relative to t_base
    int             n_rise [NCH];
    int             n_fall [NCH];
    int             n_long [NCH];
    int             t_rise [NCH];
    int             t_long [NCH];
    int             t_base;
    bit             cap_valid;
    logic [NCH-1:0] cap_rise, cap_fall;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 4'h0;
        m_due   = 4'h0;
        q_raw.delete();
        q_s2.delete();
        q_raw.push_back(4'h0);
        q_raw.push_back(4'h0);
        for (int c = 0; c < NCH; c++) m_ticks[c] = 0;
        m_edge = 0;
    endtask

    task automatic clear_counts();
        for (int c = 0; c < NCH; c++) begin
            n_rise[c] = 0; n_fall[c] = 0; n_long[c] = 0;
            t_rise[c] = -1000; t_long[c] = -1000;
        end
        t_base    = m_edge;
        cap_valid = 1'b0;
        cap_rise  = 4'h0;
        cap_fall  = 4'h0;
    endtask

    // A level is accepted when the last LIM synchronised samples all disagree with it.
    task automatic model_edge();
        logic [NCH-1:0] prev, s2;
        bit             all_opp, tick;
        prev = m_state;
        q_raw.push_back(i_Switch);
        s2 = q_raw[q_raw.size() - 3];
        if (q_raw.size() > 3) void'(q_raw.pop_front());
        q_s2.push_back(s2);
        if (q_s2.size() > LIM) void'(q_s2.pop_front());
        for (int c = 0; c < NCH; c++) begin
            all_opp = (q_s2.size() == LIM);
            foreach (q_s2[e]) if (q_s2[e][c] == m_state[c]) all_opp = 1'b0;
            if (all_opp) m_state[c] = ~m_state[c];
        end
        exp_rise = m_state & ~prev;
        exp_fall = ~m_state & prev;
        tick     = ((m_edge % LIM) == (LIM - 1));
        exp_long = 4'h0;
        for (int c = 0; c < NCH; c++) begin
            exp_long[c] = LONG_ON && m_due[c] && prev[c];
            m_due[c]    = 1'b0;
            if (!prev[c]) begin
                m_ticks[c] = 0;
            end else if (tick) begin
                m_ticks[c]++;
                if (m_ticks[c] == LT) m_due[c] = 1'b1;
            end
        end
        m_edge++;
    endtask

    task automatic step(input logic [NCH-1:0] sw);
        i_Switch = sw;
        @(posedge i_Clk);
        model_edge();
        #1;
        check_val("o_Switch", o_Switch, m_state);
        check_val("o_Rise", o_Rise, exp_rise);
        check_val("o_Fall", o_Fall, exp_fall);
        check_val("o_Long", o_Long, exp_long);
        if (!cap_valid && ((o_Rise | o_Fall) != 4'h0)) begin
            cap_valid = 1'b1;
            cap_rise  = o_Rise;
            cap_fall  = o_Fall;
        end
        for (int c = 0; c < NCH; c++) begin
            if (o_Rise[c]) begin n_rise[c]++; t_rise[c] = m_edge - 1 - t_base; end
            if (o_Fall[c]) n_fall[c]++;
            if (o_Long[c]) begin n_long[c]++; t_long[c] = m_edge - 1 - t_base; end
        end
    endtask

    task automatic do_reset(input logic [NCH-1:0] sw, input int cyc);
        i_Switch = sw;
        #2;
        i_Rst = 1'b1;
        #1;
        check_val("rst_sw", o_Switch, 4'h0);
        check_val("rst_rise", o_Rise, 4'h0);
        check_val("rst_fall", o_Fall, 4'h0);
        check_val("rst_long", o_Long, 4'h0);
        repeat (cyc) @(posedge i_Clk);
        @(negedge i_Clk);
        check_val("rst_hold_sw", o_Switch, 4'h0);
        i_Rst = 1'b0;
        model_reset();
        clear_counts();
    endtask

    int             rem [NCH];
    logic [NCH-1:0] lvl;

    initial begin
        // reset with all switches high, then debounce from edge 0
        do_reset(4'hF, 3);
        repeat (12) step(4'hF);
        for (int c = 0; c < NCH; c++) begin
            check_val("rst_rise_edge", t_rise[c], 9);
            check_val("rst_rise_cnt", n_rise[c], 1);
            check_val("rst_fall_cnt", n_fall[c], 0);
        end

        // glitch reject (7 clocks) and accept (8 clocks) on ch0
        repeat (12) step(4'h0);
        clear_counts();
        repeat (7) step(4'h1);
        repeat (12) step(4'h0);
        check_val("glitch7_rise", n_rise[0], 0);
        clear_counts();
        repeat (8) step(4'h1);
        repeat (4) step(4'h0);
        check_val("glitch8_edge", t_rise[0], 9);
        repeat (12) step(4'h0);

        // bounce on ch1 for 30 clocks then settle high
        clear_counts();
        for (int k = 0; k < 30; k++) step((((k / 3) % 2) == 0) ? 4'h2 : 4'h0);
        repeat (12) step(4'h2);
        check_val("bounce_rise_cnt", n_rise[1], 1);
        check_val("bounce_rise_edge", t_rise[1], 39);
        check_val("bounce_fall_cnt", n_fall[1], 0);

        // simultaneous ch1 rise and ch2 fall
        repeat (12) step(4'h4);
        clear_counts();
        repeat (12) step(4'h2);
        check_val("simul_rise", cap_rise, 4'h2);
        check_val("simul_fall", cap_fall, 4'h4);
        check_val("simul_edge", t_rise[1], 9);

        // long press on ch3, long hold, then re-press
        clear_counts();
        repeat (140) step(4'h8);
        check_val("long_cnt", n_long[3], LONG_ON ? 1 : 0);
        check_val("long_delay", ((t_long[3] - t_rise[3]) >= 25) && ((t_long[3] - t_rise[3]) <= 33), LONG_ON);
        repeat (12) step(4'h0);
        clear_counts();
        repeat (45) step(4'h8);
        check_val("long_repress_cnt", n_long[3], LONG_ON ? 1 : 0);

        // randomised segments per channel
        for (int c = 0; c < NCH; c++) rem[c] = 0;
        lvl = 4'h0;
        for (int n = 0; n < 400; n++) begin
            for (int c = 0; c < NCH; c++) begin
                if (rem[c] == 0) begin
                    lvl[c] = 1'($urandom_range(0, 1));
                    rem[c] = (c == 3) ? $urandom_range(1, 60) : $urandom_range(1, 14);
                end
                rem[c]--;
            end
            step(lvl);
        end

        // reset while ch0 is mid-count, ch3 settled high
        repeat (14) step(4'h8);
        repeat (7) step(4'h9);
        do_reset(4'h9, 2);
        repeat (12) step(4'h9);
        check_val("midrst_rise0", t_rise[0], 9);
        check_val("midrst_rise3", t_rise[3], 9);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
